keypad_scan: RTL and testbench
==============================

// Module: keypad_scan
// PURPOSE
//   Input-side companion to the seven-segment display driver: scans a 4x4 matrix keypad by
//   strobing rows and sampling columns, debounces keys, and emits one pulse per press.
//   Optionally shifts the entered hex digits into a 16-bit word that feeds the display driver's data[15:0].
// PARAMETERS
//   SCAN_DIV        200000  clk cycles per row step (row settle time + scan rate)
//   DEBOUNCE_SCANS  4       consecutive identical full scans needed to accept a press or a release
// PORTS
//   clk        in   1   system clock; all logic on posedge
//   rst        in   1   synchronous, active-high reset
//   row        out  4   row strobe, active-low, exactly one bit low at all times
//   col        in   4   column sense, active-low (pulled up), asynchronous to clk
//   key_valid  out  1   one-cycle pulse: debounced press accepted
//   key_code   out  4   code of the last accepted key; held until the next press
//   value      out  16  entered-digit shift register (KEYPAD_ACCUM_EN only)
// BEHAVIOUR
//   Reset: row=4'b1110, key_valid=0, key_code=0, value=0, FSM=IDLE, all counters 0.
//   Sync: col passes through a 2-FF synchronizer; all decisions use the synced value.
//   Row step: div counts 0..SCAN_DIV-1. At div==SCAN_DIV-1 (step end): sample the synced col for the
//     current row, then advance row 1110->1101->1011->0111->1110 (row index r = 0..3).
//   Scan result: built over one full scan, rows 0..3. Exactly one low col bit (index c) in exactly one row
//     -> SINGLE(code = 4*r + c). Zero low bits -> NONE.
//     >1 low bit in one row, or hits in >1 row -> NONE (ghost rejection).
//   Scan end: the step end of row 3. The FSM updates only at scan end:
//     IDLE:     SINGLE(k) -> cand=k, cnt=1, DEBOUNCE; else stay.
//     DEBOUNCE: SINGLE(cand) -> cnt+1; when cnt+1==DEBOUNCE_SCANS -> key_valid=1, key_code=cand, PRESSED.
//               SINGLE(k!=cand) -> cand=k, cnt=1, stay. NONE -> IDLE.
//     PRESSED:  result != SINGLE(cand) -> rcnt+1; rcnt+1==DEBOUNCE_SCANS -> IDLE, rcnt=0.
//               SINGLE(cand) -> rcnt=0. No repeat pulses while held.
//   DEBOUNCE_SCANS==1: accept on the first SINGLE scan (IDLE->PRESSED directly, with pulse).
//   key_valid: registered; high for exactly the cycle after the accepting scan end; never two in a row.
//   Latency: press-to-pulse = DEBOUNCE_SCANS scans + sync delay (<= (DEBOUNCE_SCANS+1)*4*SCAN_DIV+3 clk).
//   Reset mid-scan or mid-debounce: all state returns to reset values on the next edge; no pulse is emitted.
//   Counter widths: div = $clog2(SCAN_DIV) bits; cnt/rcnt = $clog2(DEBOUNCE_SCANS+1) bits.
// CONFIGURATION
//   KEYPAD_ACCUM_EN defined: on each key_valid, value <= {value[11:0], key_code}, updated in the same cycle
//     key_valid is high (visible the next cycle). Oldest digit drops out of value[15:12]; value=0 only at reset.
//   Not defined: value tied to 16'h0000; no accumulator register.
// STRUCTURE
//   keypad_pkg: FSM state encoding (IDLE, DEBOUNCE, PRESSED); row pattern constants (ROW0..ROW3 = 1110..0111);
//     NONE/SINGLE result flag.
//   Sub-module sync2 (2-FF synchronizer, width 4) is instantiated for col; scan, result and FSM stay inline.
// TESTING  (bench: SCAN_DIV=4, DEBOUNCE_SCANS=3, keypad model drives col low when a pressed key's row is low)
//   Reset: rst high for 2 clk -> row=1110, key_valid=0, key_code=0, value=0; row steps every 4 clk.
//   Press r=2,c=1 for 5 scans -> exactly one key_valid, key_code=4'h9, at the 3rd scan end +1; held key -> no more pulses.
//   Bounce: toggle key 5 every scan for 6 scans -> no pulse; then hold 3 scans -> one pulse, key_code=5.
//   Ghost: hold keys 0 and 5 together -> no pulse; release key 5 -> pulse with key_code=0 after 3 scans.
//   ACCUM_EN: press keys 1,2,3,4,5 with full releases between -> value=16'h1234, then 16'h2345.
//   Reset mid-debounce: assert rst after 2 qualifying scans -> no pulse, FSM=IDLE; restart needs 3 new scans.

Source files
------------

// File: rtl/keypad_scan_pkg.sv
// keypad_pkg: shared definitions for the 4x4 keypad scanner.
//   state_t    - debounce FSM states (IDLE, DEBOUNCE, PRESSED)
//   result_t   - outcome of one full scan (RES_NONE / RES_SINGLE)
//   ROW0..ROW3 - active-low row strobe patterns, one low bit each
//   row_pattern() - maps a row index 0..3 onto its strobe pattern
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED
  } state_t;

  typedef enum logic {
    RES_NONE,
    RES_SINGLE
  } result_t;

  localparam logic [3:0] ROW0 = 4'b1110;
  localparam logic [3:0] ROW1 = 4'b1101;
  localparam logic [3:0] ROW2 = 4'b1011;
  localparam logic [3:0] ROW3 = 4'b0111;

  function automatic logic [3:0] row_pattern(input logic [1:0] idx);
    logic [3:0] pat;
    case (idx)
      2'd0:    pat = ROW0;
      2'd1:    pat = ROW1;
      2'd2:    pat = ROW2;
      default: pat = ROW3;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// keypad_scan_if: keypad-facing and consumer-facing signals of the scanner.
//   row       - row strobe, active-low, one bit low at a time
//   col       - column sense, active-low, asynchronous to clk
//   key_valid - one-cycle pulse per accepted press
//   key_code  - code of the last accepted key (4*row + col)
//   value     - shift register of entered digits (zero unless accumulation is built in)
// Modports: master = the scanner, slave = keypad matrix / display side.
interface keypad_scan_if;

  logic [3:0]  row;
  logic [3:0]  col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] value;

  modport master (
    output row,
    output key_valid,
    output key_code,
    output value,
    input  col
  );

  modport slave (
    input  row,
    input  key_valid,
    input  key_code,
    input  value,
    output col
  );

endinterface

// File: rtl/keypad_scan_sync2.sv
// sync2: two-flop synchronizer for a bus of independent asynchronous bits.
//   clk, rst - clock and synchronous active-high reset
//   d        - asynchronous input
//   q        - synchronized output, two clk cycles of latency
// Reset value defaults to all ones so that a pulled-up, idle column bus
// does not look like a key press while leaving reset.
module sync2 #(
  parameter int                WIDTH     = 4,
  parameter logic [WIDTH-1:0]  RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // First flop may go metastable; second flop gives it a full cycle to settle.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with debounce and one pulse per press.
//   clk  - system clock, all logic on posedge
//   rst  - synchronous, active-high reset
//   bus  - keypad_scan_if.master: row (out), col (in), key_valid, key_code, value (out)
// Parameters:
//   SCAN_DIV       - clk cycles per row step
//   DEBOUNCE_SCANS - identical full scans needed to accept a press or a release
// Build option:
//   KEYPAD_ACCUM_EN - when defined, every accepted key is shifted into value[3:0]
//                     (older digits move up, oldest drops out of value[15:12]);
//                     when undefined, value is tied to zero.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 200000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic          clk,
  input  logic          rst,
  keypad_scan_if.master bus
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [3:0]       colSync;
  logic [DIV_W-1:0] div;
  logic [1:0]       rowIdx;
  logic             stepEnd;
  logic             scanEnd;

  // Per-row decode of the synced columns
  logic [3:0] lowBits;
  logic       rowHit;
  logic       rowMulti;
  logic [1:0] rowCol;

  // Scan accumulation (rows already finished in this scan)
  logic       hitSeen;
  logic       ghost;
  logic [3:0] accCode;
  logic       mergedHit;
  logic       mergedGhost;
  logic [3:0] mergedCode;
  result_t    scanResult;

  // Debounce FSM
  state_t     state, stateNext;
  logic [3:0] cand, candNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [CNT_W-1:0] rcnt, rcntNext;
  logic       keyValid, keyValidNext;
  logic [3:0] keyCode, keyCodeNext;
  logic       isCand;

  sync2 #(.WIDTH(4), .RESET_VAL(4'hF)) u_colSync (
    .clk (clk),
    .rst (rst),
    .d   (bus.col),
    .q   (colSync)
  );

  assign stepEnd = (div == DIV_LAST);
  assign scanEnd = stepEnd && (rowIdx == 2'd3);

  // Row step timer; the row index advances at the end of each step so the
  // strobe is stable for a full SCAN_DIV period before its columns are sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      div    <= '0;
      rowIdx <= 2'd0;
    end else if (stepEnd) begin
      div    <= '0;
      rowIdx <= rowIdx + 2'd1;
    end else begin
      div    <= div + DIV_W'(1);
    end
  end

  // Decode the current row: any low bit, more than one low bit, and the
  // index of the lowest low bit.
  always_comb begin
    lowBits  = ~colSync;
    rowHit   = |lowBits;
    rowMulti = (lowBits & (lowBits - 4'd1)) != 4'd0;
    rowCol   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (lowBits[i]) rowCol = 2'(i);
    end
  end

  // Fold the current row into the scan so far. A second hit anywhere in the
  // scan, or several columns in one row, marks the scan as ghosted.
  always_comb begin
    mergedHit   = hitSeen | rowHit;
    mergedGhost = ghost | rowMulti | (hitSeen & rowHit);
    mergedCode  = (rowHit && !hitSeen) ? {rowIdx, rowCol} : accCode;
    scanResult  = (mergedHit && !mergedGhost) ? RES_SINGLE : RES_NONE;
  end

  // Accumulators restart at every scan end; the FSM consumes the merged
  // result on that same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      hitSeen <= 1'b0;
      ghost   <= 1'b0;
      accCode <= 4'd0;
    end else if (stepEnd) begin
      if (rowIdx == 2'd3) begin
        hitSeen <= 1'b0;
        ghost   <= 1'b0;
        accCode <= 4'd0;
      end else begin
        hitSeen <= mergedHit;
        ghost   <= mergedGhost;
        accCode <= mergedCode;
      end
    end
  end

  // FSM state register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cand     <= 4'd0;
      cnt      <= '0;
      rcnt     <= '0;
      keyValid <= 1'b0;
      keyCode  <= 4'd0;
    end else begin
      state    <= stateNext;
      cand     <= candNext;
      cnt      <= cntNext;
      rcnt     <= rcntNext;
      keyValid <= keyValidNext;
      keyCode  <= keyCodeNext;
    end
  end

  // Next-state logic; decisions are taken only at scan end so every count
  // corresponds to one complete scan of the matrix.
  always_comb begin
    stateNext    = state;
    candNext     = cand;
    cntNext      = cnt;
    rcntNext     = rcnt;
    keyValidNext = 1'b0;
    keyCodeNext  = keyCode;
    isCand       = (scanResult == RES_SINGLE) && (mergedCode == cand);

    if (scanEnd) begin
      case (state)
        IDLE: begin
          if (scanResult == RES_SINGLE) begin
            candNext = mergedCode;
            if (DEBOUNCE_SCANS == 1) begin
              keyValidNext = 1'b1;
              keyCodeNext  = mergedCode;
              cntNext      = '0;
              rcntNext     = '0;
              stateNext    = PRESSED;
            end else begin
              cntNext   = CNT_ONE;
              stateNext = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (isCand) begin
            if (CNT_W'(cnt + CNT_ONE) == CNT_TARGET) begin
              keyValidNext = 1'b1;
              keyCodeNext  = cand;
              cntNext      = '0;
              rcntNext     = '0;
              stateNext    = PRESSED;
            end else begin
              cntNext = CNT_W'(cnt + CNT_ONE);
            end
          end else if (scanResult == RES_SINGLE) begin
            candNext = mergedCode;
            cntNext  = CNT_ONE;
          end else begin
            cntNext   = '0;
            stateNext = IDLE;
          end
        end
        PRESSED: begin
          // Any scan that is not the held key counts toward release; a
          // single matching scan restarts the release count.
          if (!isCand) begin
            if (CNT_W'(rcnt + CNT_ONE) == CNT_TARGET) begin
              rcntNext  = '0;
              stateNext = IDLE;
            end else begin
              rcntNext = CNT_W'(rcnt + CNT_ONE);
            end
          end else begin
            rcntNext = '0;
          end
        end
        default: begin
          stateNext = IDLE;
          cntNext   = '0;
          rcntNext  = '0;
        end
      endcase
    end
  end

`ifdef KEYPAD_ACCUM_EN
  logic [15:0] valueReg;

  // Shift in the new digit while key_valid is high; key_code already holds
  // it, so the updated word appears the cycle after the pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      valueReg <= 16'h0000;
    end else if (keyValid) begin
      valueReg <= {valueReg[11:0], keyCode};
    end
  end

  assign bus.value = valueReg;
`else
  assign bus.value = 16'h0000;
`endif

  assign bus.row       = row_pattern(rowIdx);
  assign bus.key_valid = keyValid;
  assign bus.key_code  = keyCode;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: self-checking bench for keypad_scan (SCAN_DIV=4, DEBOUNCE_SCANS=3).
// A keypad model pulls a column low when a pressed key's row strobe is low.
// Expected key codes are queued when a press is driven and popped by a
// monitor on every key_valid pulse; value is checked the cycle after.
module tb_keypad_scan;

  localparam int SCAN_CYC = 16;
  localparam int NVEC     = 34;

  typedef struct {
    logic [15:0] keys;
    int          scans;
    int          pulses;
    logic [3:0]  code;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] pressed = 16'h0000;
  logic [3:0]  colModel;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int lastPulseCyc = -1;
  int cyc = 0;

  logic [3:0]  expQ[$];
  logic [15:0] expValue = 16'h0000;
  bit          valuePending = 1'b0;
  bit          prevValid = 1'b0;
  logic [3:0]  popCode;

  vec_t vecs[NVEC];

  always #5 clk = ~clk;

  keypad_scan_if bus();

  keypad_scan #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Keypad matrix model: a pressed key connects its row to its column.
  always_comb begin
    colModel = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[4*r + c] && !bus.row[r]) colModel[c] = 1'b0;
      end
    end
  end
  assign bus.col = colModel;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: bound expired", name);
  endtask

  // Returns #1 after the next scan-end edge (row goes 0111 -> 1110).
  task automatic waitScanEnd();
    int n;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (bus.row != 4'b0111 && n < 4*SCAN_CYC);
    if (bus.row != 4'b0111) failNow("wait_row3");
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (bus.row != 4'b1110 && n < 4*SCAN_CYC);
    if (bus.row != 4'b1110) failNow("wait_scan_end");
  endtask

  task automatic waitPulse(input int p0, input int limit);
    int n;
    n = 0;
    while (pulses == p0 && n < limit) begin
      @(negedge clk); n++;
    end
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    int p0;
    p0 = pulses;
    pressed = v.keys;
    for (int k = 0; k < v.pulses; k++) expQ.push_back(v.code);
    repeat (v.scans) waitScanEnd();
    checkOutput($sformatf("vec%0d_pulses", idx), pulses - p0, v.pulses);
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      valuePending = 1'b0;
      prevValid    = 1'b0;
    end else begin
      if (valuePending) begin
        checkOutput("value", bus.value, expValue);
        valuePending = 1'b0;
      end
      if (bus.key_valid) begin
        pulses++;
        lastPulseCyc = cyc;
        checkOutput("pulse_back_to_back", prevValid, 0);
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_pulse: got key_code %0h, expected no pulse", bus.key_code);
        end else begin
          popCode = expQ.pop_front();
          checkOutput("key_code", bus.key_code, popCode);
`ifdef KEYPAD_ACCUM_EN
          expValue = {expValue[11:0], popCode};
`endif
          valuePending = 1'b1;
        end
      end
      prevValid = bus.key_valid;
    end
  end

  initial begin
    int p0;
    int s;
    logic [15:0] accExp;

    vecs[0]  = '{16'h0000, 4, 0, 4'h0};
    vecs[1]  = '{16'h0020, 1, 0, 4'h0};
    vecs[2]  = '{16'h0000, 1, 0, 4'h0};
    vecs[3]  = '{16'h0020, 1, 0, 4'h0};
    vecs[4]  = '{16'h0000, 1, 0, 4'h0};
    vecs[5]  = '{16'h0020, 1, 0, 4'h0};
    vecs[6]  = '{16'h0000, 1, 0, 4'h0};
    vecs[7]  = '{16'h0020, 4, 1, 4'h5};
    vecs[8]  = '{16'h0000, 4, 0, 4'h0};
    vecs[9]  = '{16'h0021, 4, 0, 4'h0};
    vecs[10] = '{16'h0001, 4, 1, 4'h0};
    vecs[11] = '{16'h0000, 4, 0, 4'h0};
    vecs[12] = '{16'h0030, 4, 0, 4'h0};
    vecs[13] = '{16'h0008, 2, 0, 4'h0};
    vecs[14] = '{16'h1000, 4, 1, 4'hC};
    vecs[15] = '{16'h0000, 4, 0, 4'h0};
    vecs[16] = '{16'h0040, 4, 1, 4'h6};
    vecs[17] = '{16'h0000, 1, 0, 4'h0};
    vecs[18] = '{16'h0040, 3, 0, 4'h0};
    vecs[19] = '{16'h0000, 2, 0, 4'h0};
    vecs[20] = '{16'h0040, 2, 0, 4'h0};
    vecs[21] = '{16'h0000, 4, 0, 4'h0};
    vecs[22] = '{16'h8000, 4, 1, 4'hF};
    vecs[23] = '{16'h0000, 4, 0, 4'h0};
    vecs[24] = '{16'h0002, 4, 1, 4'h1};
    vecs[25] = '{16'h0000, 4, 0, 4'h0};
    vecs[26] = '{16'h0004, 4, 1, 4'h2};
    vecs[27] = '{16'h0000, 4, 0, 4'h0};
    vecs[28] = '{16'h0008, 4, 1, 4'h3};
    vecs[29] = '{16'h0000, 4, 0, 4'h0};
    vecs[30] = '{16'h0010, 4, 1, 4'h4};
    vecs[31] = '{16'h0000, 4, 0, 4'h0};
    vecs[32] = '{16'h0020, 4, 1, 4'h5};
    vecs[33] = '{16'h0000, 4, 0, 4'h0};

    // Reset for two clocks
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_row", bus.row, 4'b1110);
    checkOutput("rst_key_valid", bus.key_valid, 0);
    checkOutput("rst_key_code", bus.key_code, 0);
    checkOutput("rst_value", bus.value, 0);
    rst = 1'b0;

    // Row steps every 4 clocks; the 16th edge is a scan end
    repeat (3) @(posedge clk);
    #1 checkOutput("row_hold", bus.row, 4'b1110);
    @(posedge clk);
    #1 checkOutput("row_step1", bus.row, 4'b1101);
    repeat (4) @(posedge clk);
    #1 checkOutput("row_step2", bus.row, 4'b1011);
    repeat (4) @(posedge clk);
    #1 checkOutput("row_step3", bus.row, 4'b0111);
    repeat (4) @(posedge clk);
    #1 checkOutput("row_wrap", bus.row, 4'b1110);

    // Press r=2,c=1 right after a scan end: pulse at the 3rd scan end
    p0 = pulses;
    s = cyc;
    pressed = 16'h0200;
    expQ.push_back(4'h9);
    waitPulse(p0, 6*SCAN_CYC);
    checkOutput("press9_pulses", pulses - p0, 1);
    checkOutput("press9_latency", lastPulseCyc - s, 3*SCAN_CYC);
    waitScanEnd();
    waitScanEnd();
    checkOutput("press9_held_no_repeat", pulses - p0, 1);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(i, vecs[i]);
      if (i == 31) begin
`ifdef KEYPAD_ACCUM_EN
        accExp = 16'h1234;
`else
        accExp = 16'h0000;
`endif
        checkOutput("value_1234", bus.value, accExp);
      end
    end

`ifdef KEYPAD_ACCUM_EN
    accExp = 16'h2345;
`else
    accExp = 16'h0000;
`endif
    checkOutput("value_2345", bus.value, accExp);
    checkOutput("queue_empty", expQ.size(), 0);

    // Reset after two qualifying scans: no pulse, and three fresh scans needed
    p0 = pulses;
    pressed = 16'h0080;
    waitScanEnd();
    waitScanEnd();
    checkOutput("midrst_no_early", pulses - p0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    expValue = 16'h0000;
    s = cyc;
    checkOutput("midrst_row", bus.row, 4'b1110);
    checkOutput("midrst_key_valid", bus.key_valid, 0);
    checkOutput("midrst_key_code", bus.key_code, 0);
    expQ.push_back(4'h7);
    waitPulse(p0, 6*SCAN_CYC);
    checkOutput("midrst_pulses", pulses - p0, 1);
    checkOutput("midrst_latency", lastPulseCyc - s, 3*SCAN_CYC);
    repeat (3) @(negedge clk);
    checkOutput("final_queue_empty", expQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
